i2s_receive: RTL and testbench
==============================

// Module: i2s_receive
// PURPOSE
//  Upstream feeder for the S/PDIF transmitter: deserialises an external I2S stereo stream
//  into 24-bit left/right pairs, buffers them in a small FIFO, and serves them on the
//  transmitter's dreq/drdy handshake. Sits between the board I2S pins and spdif_transmit.
//  Connect o_ldata/o_rdata/o_drdy to i_ldata/i_rdata/i_drdy and o_dreq to i_dreq.
//  I2S pins are asynchronous to i_clk; i_clk must be >= 8x the bclk frequency.
// PARAMETERS
//  DATA_WIDTH  24  sample width presented on o_ldata/o_rdata
//  FIFO_AW     2   FIFO address bits; depth = 2**FIFO_AW stereo pairs
// PORTS
//  i_clk      in   1              system clock; all outputs change on its rising edge
//  i_rst_n    in   1              reset; asynchronous, active-low
//  i_bclk     in   1              I2S bit clock (async)
//  i_lrclk    in   1              I2S word select (async); 0 = left, 1 = right
//  i_sdata    in   1              I2S serial data (async), MSB first
//  i_dreq     in   1              sample request from transmitter; the rising edge is the request
//  o_ldata    out  DATA_WIDTH     left sample, valid when o_drdy is high, held until next pop
//  o_rdata    out  DATA_WIDTH     right sample, same timing as o_ldata
//  o_drdy     out  1              one-cycle pulse: new pair presented
//  o_fill     out  FIFO_AW+1      pairs currently stored
// BEHAVIOUR
//  - Reset: o_ldata/o_rdata = 0, o_drdy = 0, o_fill = 0, FIFO empty, all sync flops 0,
//    framing lost (sync = 0), left hold register invalid.
//  - Input capture: i_bclk, i_lrclk, i_sdata each pass through a 2-flop synchroniser.
//    A bclk rising edge (sync'd 0->1) samples the lrclk and sdata values.
//  - Word boundary: a sampled lrclk differs from the previous sampled lrclk (lr_prev).
//    The sdata bit sampled at that edge is the LSB of the word for channel lr_prev.
//    That bit is shifted in, the word is committed, then the bit counter clears.
//  - Bit placement: bit k of a word (k = 0 is MSB) goes to position DATA_WIDTH-1-k.
//    Bits with k >= DATA_WIDTH are ignored. Short words are zero-filled at the LSBs.
//    The bit counter saturates and does not wrap.
//  - Sync: the first boundary after reset sets sync = 1 and discards the partial word.
//  - Commit: lr_prev = 0 stores the word in the left hold register and marks it valid.
//    lr_prev = 1 with left valid pushes {left,right} into the FIFO and clears left valid.
//    lr_prev = 1 without left valid drops the right word.
//  - Push when full: the pair is dropped and FIFO contents are unchanged (overflow).
//  - Pop: i_dreq = 1 with the previous i_dreq = 0, detected in cycle N.
//    If non-empty, the head pair is written to o_ldata/o_rdata and o_drdy = 1 in cycle N+1.
//    If empty, there is no o_drdy, outputs hold their value, and the event is an underflow.
//  - Same-cycle push and pop: the pop uses pre-push state, so there is no fall-through.
//    Empty: the pop underflows and the push succeeds.
//    Full: both succeed, o_fill is unchanged, and there is no overflow.
//  - o_fill: updates in the cycle after a push/pop; ranges 0..2**FIFO_AW. Pointers wrap modulo depth.
//  - Reset asserted mid-word: immediate return to the reset state; the partial frame is lost.
// CONFIGURATION
//  Macro I2S_RX_STATUS_EN:
//   - Defined: adds ports o_overflow (out, 1), o_underflow (out, 1), i_clr_status (in, 1).
//     Flags are sticky and set the cycle after the event.
//     i_clr_status = 1 clears both; a same-cycle event wins over the clear. Reset value is 0.
//   - Undefined: these ports and flops do not exist. Drop/ignore behaviour is identical.
// TESTING
//  Conditions: i_clk 100 MHz; bclk period 160 ns; 32 bclk per channel unless stated.
//  1. Hold i_rst_n = 0, toggle all inputs -> o_drdy = 0, o_ldata = o_rdata = 0, o_fill = 0.
//  2. Sync frame, then L = 24'h800000, R = 24'h000001 (8 trailing 0 bits) -> o_fill = 1;
//     dreq rise -> next cycle o_drdy = 1, o_ldata = 800000, o_rdata = 000001; o_fill = 0.
//  3. 16 bclk/channel, L = 16'hABCD, R = 16'h1234 -> pop gives o_ldata = 24'hABCD00,
//     o_rdata = 24'h123400.
//  4. FIFO_AW = 2: push 5 frames with no dreq -> o_fill = 4, o_overflow = 1;
//     4 pops return frames 1-4 in order.
//  5. dreq rise with FIFO empty -> no o_drdy, outputs unchanged, o_underflow = 1;
//     i_clr_status pulse -> o_underflow = 0.
//  6. Assert reset mid-left-word, release -> the first partial pair is discarded;
//     the first pop returns the first complete L/R pair after resync.

Source files
------------

// File: rtl/i2s_receive.sv
`default_nettype none
// ============================================================================
// Module   : i2s_receive
// Purpose  : Deserialises an external I2S stereo stream into DATA_WIDTH-bit
//            left/right pairs, buffers them in a small FIFO and serves them
//            to the S/PDIF transmitter on its dreq/drdy handshake.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk         in   1            system clock (>= 8x bclk)
//   i_rst_n       in   1            asynchronous active-low reset
//   i_bclk        in   1            I2S bit clock (asynchronous)
//   i_lrclk       in   1            I2S word select, 0 = left (asynchronous)
//   i_sdata       in   1            I2S serial data, MSB first (asynchronous)
//   i_dreq        in   1            sample request, rising edge requests
//   o_ldata       out  DATA_WIDTH   left sample, held until next pop
//   o_rdata       out  DATA_WIDTH   right sample, same timing as o_ldata
//   o_drdy        out  1            one-cycle pulse: new pair presented
//   o_fill        out  FIFO_AW+1    pairs currently stored
//   o_overflow    out  1            sticky push-when-full flag   (I2S_RX_STATUS_EN)
//   o_underflow   out  1            sticky pop-when-empty flag   (I2S_RX_STATUS_EN)
//   i_clr_status  in   1            clears both sticky flags     (I2S_RX_STATUS_EN)
// Configuration
//   I2S_RX_STATUS_EN  when defined, adds the sticky status flags and clear.
// ============================================================================
module i2s_receive #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_AW    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_bclk,
  input  logic                  i_lrclk,
  input  logic                  i_sdata,
  input  logic                  i_dreq,
  output logic [DATA_WIDTH-1:0] o_ldata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_drdy,
`ifdef I2S_RX_STATUS_EN
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_status,
`endif
  output logic [FIFO_AW:0]      o_fill
);

  localparam int C_DEPTH = 1 << FIFO_AW;
  localparam int C_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX   = C_CNT_W'(DATA_WIDTH);
  localparam logic [FIFO_AW:0]   C_FILL_FULL = (FIFO_AW + 1)'(C_DEPTH);

  // --------------------------------------------------------------------------
  // Input synchronisers. All three pins share the same depth so that the
  // sampled lrclk/sdata line up with the detected bclk edge.
  // --------------------------------------------------------------------------
  logic r_bclk_meta, r_bclk_sync, r_bclk_last;
  logic r_lrclk_meta, r_lrclk_sync;
  logic r_sdata_meta, r_sdata_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bclk_meta  <= 1'b0;
      r_bclk_sync  <= 1'b0;
      r_bclk_last  <= 1'b0;
      r_lrclk_meta <= 1'b0;
      r_lrclk_sync <= 1'b0;
      r_sdata_meta <= 1'b0;
      r_sdata_sync <= 1'b0;
    end else begin
      r_bclk_meta  <= i_bclk;
      r_bclk_sync  <= r_bclk_meta;
      r_bclk_last  <= r_bclk_sync;
      r_lrclk_meta <= i_lrclk;
      r_lrclk_sync <= r_lrclk_meta;
      r_sdata_meta <= i_sdata;
      r_sdata_sync <= r_sdata_meta;
    end
  end

  logic w_bclk_rise;
  assign w_bclk_rise = r_bclk_sync & ~r_bclk_last;

  // --------------------------------------------------------------------------
  // Word assembly
  // --------------------------------------------------------------------------
  logic                  r_lr_prev;
  logic                  r_sync;
  logic [C_CNT_W-1:0]    r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_left;
  logic                  r_left_vld;

  logic                  w_boundary;
  logic                  w_commit;
  logic                  w_commit_left;
  logic                  w_push_req;
  logic [DATA_WIDTH-1:0] w_word;

  // Current word with the just-sampled bit dropped into its MSB-first slot.
  // Bits beyond DATA_WIDTH leave the word untouched (counter saturates).
  always_comb begin
    w_word = r_shift;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (r_bit_cnt == C_CNT_W'(i)) begin
        w_word[DATA_WIDTH-1-i] = r_sdata_sync;
      end
    end
  end

  assign w_boundary    = w_bclk_rise & (r_lrclk_sync != r_lr_prev);
  assign w_commit      = w_boundary & r_sync;
  assign w_commit_left = w_commit & ~r_lr_prev;
  // A right word only forms a pair when a left word is waiting; otherwise it
  // is dropped so that the FIFO never holds a mismatched pair.
  assign w_push_req    = w_commit & r_lr_prev & r_left_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lr_prev  <= 1'b0;
      r_sync     <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_left     <= '0;
      r_left_vld <= 1'b0;
    end else begin
      if (w_bclk_rise) begin
        r_lr_prev <= r_lrclk_sync;
        if (w_boundary) begin
          // Clearing the shifter zero-fills the LSBs of short words.
          r_shift   <= '0;
          r_bit_cnt <= '0;
          r_sync    <= 1'b1;
        end else begin
          r_shift <= w_word;
          if (r_bit_cnt != C_CNT_MAX) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
      end
      if (w_commit_left) begin
        r_left     <= w_word;
        r_left_vld <= 1'b1;
      end else if (w_push_req) begin
        r_left_vld <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pair FIFO
  // --------------------------------------------------------------------------
  logic [2*DATA_WIDTH-1:0] r_mem [0:C_DEPTH-1];
  logic [FIFO_AW-1:0]      r_wptr;
  logic [FIFO_AW-1:0]      r_rptr;
  logic [FIFO_AW:0]        r_fill;
  logic                    r_dreq_last;
  logic [DATA_WIDTH-1:0]   r_ldata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_drdy;

  logic w_empty, w_full, w_pop_req, w_pop, w_push;

  assign w_empty   = (r_fill == '0);
  assign w_full    = (r_fill == C_FILL_FULL);
  assign w_pop_req = i_dreq & ~r_dreq_last;
  // Pop and push both see pre-push state: no fall-through into an empty
  // FIFO, while a pop from a full FIFO frees the slot being written.
  assign w_pop     = w_pop_req & ~w_empty;
  assign w_push    = w_push_req & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_left, w_word};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fill      <= '0;
      r_dreq_last <= 1'b0;
      r_ldata     <= '0;
      r_rdata     <= '0;
      r_drdy      <= 1'b0;
    end else begin
      r_dreq_last <= i_dreq;
      r_drdy      <= w_pop;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        {r_ldata, r_rdata} <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign o_ldata = r_ldata;
  assign o_rdata = r_rdata;
  assign o_drdy  = r_drdy;
  assign o_fill  = r_fill;

  // --------------------------------------------------------------------------
  // Optional sticky status flags
  // --------------------------------------------------------------------------
`ifdef I2S_RX_STATUS_EN
  logic r_overflow, r_underflow;
  logic w_overflow_evt, w_underflow_evt;

  assign w_overflow_evt  = w_push_req & w_full & ~w_pop;
  assign w_underflow_evt = w_pop_req & w_empty;

  // A same-cycle event takes priority over the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_overflow_evt) begin
        r_overflow <= 1'b1;
      end else if (i_clr_status) begin
        r_overflow <= 1'b0;
      end
      if (w_underflow_evt) begin
        r_underflow <= 1'b1;
      end else if (i_clr_status) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_receive.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_receive
// Purpose  : Self-checking bench for i2s_receive. An I2S serialiser drives
//            the pins; each pair expected to land in the FIFO is pushed to a
//            scoreboard queue and compared when popped via dreq.
// Revision : 1.0  initial release
// ============================================================================
module tb_i2s_receive;

  localparam int DW = 24;
  localparam int AW = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          bclk  = 1'b0;
  logic          lrclk = 1'b0;
  logic          sdata = 1'b0;
  logic          dreq  = 1'b0;
  logic [DW-1:0] ldata;
  logic [DW-1:0] rdata;
  logic          drdy;
  logic [AW:0]   fill;
`ifdef I2S_RX_STATUS_EN
  logic          ovf;
  logic          unf;
  logic          clr = 1'b0;
`endif

  i2s_receive #(.DATA_WIDTH(DW), .FIFO_AW(AW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_bclk       (bclk),
    .i_lrclk      (lrclk),
    .i_sdata      (sdata),
    .i_dreq       (dreq),
    .o_ldata      (ldata),
    .o_rdata      (rdata),
    .o_drdy       (drdy),
`ifdef I2S_RX_STATUS_EN
    .o_overflow   (ovf),
    .o_underflow  (unf),
    .i_clr_status (clr),
`endif
    .o_fill       (fill)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [2*DW-1:0] sb_q [$];
  logic [2*DW-1:0] last_pair = '0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bclk period (160 ns): data and word select change while bclk is low.
  task automatic slot(input logic lr, input logic sd);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    #80;
    bclk  = 1'b1;
    #80;
  endtask

  // I2S framing: word select flips one slot before the word ends, so the
  // last bit of a word is sent with the other channel's select value.
  task automatic send_word(input logic ch, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      slot((k == n - 1) ? ~ch : ch, d[31-k]);
    end
  endtask

  // Receiver view of an n-bit word: first min(n,24) bits MSB-aligned, rest zero.
  function automatic logic [DW-1:0] expect_word(input logic [31:0] d, input int n);
    logic [31:0] m;
    m = d & (32'hFFFF_FFFF << (32 - n));
    return m[31:8];
  endfunction

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int n,
                           input bit stored);
    send_word(1'b0, l, n);
    send_word(1'b1, r, n);
    if (stored) sb_q.push_back({expect_word(l, n), expect_word(r, n)});
  endtask

  task automatic do_pop(input string tag);
    logic [2*DW-1:0] e;
    @(negedge clk);
    dreq = 1'b1;
    @(negedge clk);
    check({tag, "_drdy"}, 48'(drdy), 48'd1);
    if (sb_q.size() == 0) begin
      e = last_pair;
    end else begin
      e = sb_q.pop_front();
    end
    check({tag, "_data"}, {ldata, rdata}, e);
    last_pair = e;
    @(negedge clk);
    check({tag, "_pulse"}, 48'(drdy), 48'd0);
    dreq = 1'b0;
  endtask

  task automatic do_underflow();
    @(negedge clk);
    dreq = 1'b1;
    @(negedge clk);
    check("unf_drdy0", 48'(drdy), 48'd0);
    check("unf_hold", {ldata, rdata}, last_pair);
    @(negedge clk);
    check("unf_drdy1", 48'(drdy), 48'd0);
    dreq = 1'b0;
  endtask

  initial begin
    // 1. Reset held with inputs toggling
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bclk  = 1'($urandom);
      lrclk = 1'($urandom);
      sdata = 1'($urandom);
      dreq  = 1'($urandom);
    end
    check("rst_drdy", 48'(drdy), 48'd0);
    check("rst_ldata", 48'(ldata), 48'd0);
    check("rst_rdata", 48'(rdata), 48'd0);
    check("rst_fill", 48'(fill), 48'd0);
    @(negedge clk);
    bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; dreq = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 2. Sync frame then a 24-bit pair in 32-bit slots
    send_word(1'b1, 32'hFFFF_FFFF, 32);
    check("sync_fill", 48'(fill), 48'd0);
    send_pair({24'h800000, 8'h00}, {24'h000001, 8'h00}, 32, 1'b1);
    check("t2_fill1", 48'(fill), 48'd1);
    do_pop("t2_pop");
    check("t2_fill0", 48'(fill), 48'd0);

    // 3. 16-bit words zero-filled at the LSBs
    send_pair({16'hABCD, 16'h0}, {16'h1234, 16'h0}, 16, 1'b1);
    do_pop("t3_pop");

    // Trailing bits beyond 24 are ignored
    send_pair({24'h5A5A5A, 8'hFF}, {24'hC3C3C3, 8'h7F}, 32, 1'b1);
    do_pop("trail_pop");

    // 4. Five frames into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      send_pair({24'h100000 + 24'(i), 8'h00}, {24'h200000 + 24'(i * 3), 8'h00}, 32, i < 4);
`ifdef I2S_RX_STATUS_EN
      if (i == 3) check("t4_ovf_before", 48'(ovf), 48'd0);
`endif
    end
    check("t4_fill4", 48'(fill), 48'd4);
`ifdef I2S_RX_STATUS_EN
    check("t4_ovf", 48'(ovf), 48'd1);
    check("t4_unf_clear", 48'(unf), 48'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      do_pop($sformatf("t4_pop%0d", i));
      check($sformatf("t4_fill_after%0d", i), 48'(fill), 48'(3 - i));
    end

    // 5. Underflow
    do_underflow();
    check("t5_fill", 48'(fill), 48'd0);
`ifdef I2S_RX_STATUS_EN
    check("t5_unf", 48'(unf), 48'd1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("t5_unf_clr", 48'(unf), 48'd0);
    check("t5_ovf_clr", 48'(ovf), 48'd0);
`endif

    // 6. Reset in the middle of a left word
    send_pair({24'h0F0F0F, 8'h00}, {24'hF0F0F0, 8'h00}, 32, 1'b0);
    check("t6_fill_pre", 48'(fill), 48'd1);
    for (int k = 0; k < 12; k++) slot(1'b0, 1'(k & 1));
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_rst_fill", 48'(fill), 48'd0);
    check("t6_rst_data", {ldata, rdata}, 48'd0);
    last_pair = '0;
    rst_n = 1'b1;
    for (int k = 12; k < 32; k++) slot((k == 31) ? 1'b1 : 1'b0, 1'(k & 1));
    send_word(1'b1, 32'hDEAD_BEEF, 32);
    check("t6_fill_dropped", 48'(fill), 48'd0);
    send_pair({24'h654321, 8'h00}, {24'hFEDCBA, 8'h00}, 32, 1'b1);
    check("t6_fill1", 48'(fill), 48'd1);
    do_pop("t6_pop");

    check("sb_empty", 48'(sb_q.size()), 48'd0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
